bram_tdp_arbiter: RTL and testbench

Round-robin arbiter sharing the two ports of a true-dual-port, read-first block RAM among `NREQ` requesters. Each cycle it grants up to two requests, one per RAM port, and blocks same-address conflicts. It returns each transfer's read data, or the old contents for writes, to the originating requester. It sits directly in front of the dual-port RAM primitive and drives its enables, write enables, addresses and write data.

---
 rtl/bram_arb_pkg.sv | 23 ++
 rtl/bram_arb_rr_pick.sv | 34 +++
 rtl/bram_tdp_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bram_tdp_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// +----------------------------------------------------------------------+
// | bram_arb_pkg - shared types for the dual-port BRAM arbiter  (rev 1.0) |
// +----------------------------------------------------------------------+
`default_nettype none

package bram_arb_pkg;

  localparam int MAX_NREQ = 8;
  localparam int ID_W     = $clog2(MAX_NREQ);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/bram_arb_rr_pick.sv
// +----------------------------------------------------------------------+
// | bram_arb_rr_pick - first eligible requester from a start pointer (1.0)|
// +----------------------------------------------------------------------+
`default_nettype none

module bram_arb_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         excl,
  input  logic [$clog2(NREQ)-1:0] start,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int PW = $clog2(NREQ);

  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(start) + i) % NREQ;
      if (!found && req[j] && !excl[j]) begin
        found = 1'b1;
        idx   = j[PW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_tdp_arbiter.sv
// +----------------------------------------------------------------------+
// | bram_tdp_arbiter - round-robin 2-port BRAM arbiter; BRAM_ARB_OUTREG_EN|
// | adds an output register stage (latency 2).                 rev 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module bram_tdp_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SIZE   = 1024,
  parameter int WIDTH  = 256,
  parameter int ADDR_W = $clog2(SIZE) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [NREQ*WIDTH-1:0]   rsp_rdata,
  output logic                    ram_ena,
  output logic                    ram_enb,
  output logic                    ram_wea,
  output logic                    ram_web,
  output logic [ADDR_W-1:0]       ram_addra,
  output logic [ADDR_W-1:0]       ram_addrb,
  output logic [WIDTH-1:0]        ram_dia,
  output logic [WIDTH-1:0]        ram_dib,
  input  logic [WIDTH-1:0]        ram_doa,
  input  logic [WIDTH-1:0]        ram_dob
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]     rr_ptr;
  logic              found_a, found_b;
  logic [PW-1:0]     idx_a, idx_b;
  logic              grant_a, grant_b;
  logic [NREQ-1:0]   conflict, excl_b;
  logic [ADDR_W-1:0] addr_a;
  logic              we_a;
  logic [PW-1:0]     last_idx, next_ptr;

  bram_arb_rr_pick #(.NREQ(NREQ)) u_pick_a (
    .req   (req_valid),
    .excl  ({NREQ{1'b0}}),
    .start (rr_ptr),
    .found (found_a),
    .idx   (idx_a)
  );

  assign addr_a = req_addr[idx_a*ADDR_W +: ADDR_W];
  assign we_a   = req_we[idx_a];

  // Port B may not take the port-A winner nor anything that collides with it
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      conflict[i] = (req_addr[i*ADDR_W +: ADDR_W] == addr_a) && (req_we[i] || we_a);
    end
    excl_b = conflict | (NREQ'(1) << idx_a);
  end

  bram_arb_rr_pick #(.NREQ(NREQ)) u_pick_b (
    .req   (req_valid),
    .excl  (excl_b),
    .start (rr_ptr),
    .found (found_b),
    .idx   (idx_b)
  );

  assign grant_a = found_a && rst_n;
  assign grant_b = found_a && found_b && rst_n;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (grant_a && (idx_a == PW'(i))) || (grant_b && (idx_b == PW'(i)));
    end
  end

  assign ram_ena   = grant_a;
  assign ram_enb   = grant_b;
  assign ram_wea   = grant_a && req_we[idx_a];
  assign ram_web   = grant_b && req_we[idx_b];
  assign ram_addra = grant_a ? addr_a : '0;
  assign ram_addrb = grant_b ? req_addr[idx_b*ADDR_W +: ADDR_W] : '0;
  assign ram_dia   = grant_a ? req_wdata[idx_a*WIDTH +: WIDTH] : '0;
  assign ram_dib   = grant_b ? req_wdata[idx_b*WIDTH +: WIDTH] : '0;

  // Port B, when granted, always sits later in scan order than port A
  assign last_idx = grant_b ? idx_b : idx_a;
  assign next_ptr = (last_idx == PW'(NREQ - 1)) ? '0 : last_idx + 1'b1;

  tag_t tag_q [0:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      tag_q[PORT_A]  <= '0;
      tag_q[PORT_B]  <= '0;
    end else begin
      if (grant_a) rr_ptr <= next_ptr;
      tag_q[PORT_A] <= '{valid: grant_a, id: ID_W'(idx_a)};
      tag_q[PORT_B] <= '{valid: grant_b, id: ID_W'(idx_b)};
    end
  end

  tag_t             rsp_tag_a, rsp_tag_b;
  logic [WIDTH-1:0] rsp_doa, rsp_dob;

`ifdef BRAM_ARB_OUTREG_EN
  tag_t             tag_s_a, tag_s_b;
  logic [WIDTH-1:0] doa_s, dob_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_s_a <= '0;
      tag_s_b <= '0;
      doa_s   <= '0;
      dob_s   <= '0;
    end else begin
      tag_s_a <= tag_q[PORT_A];
      tag_s_b <= tag_q[PORT_B];
      doa_s   <= ram_doa;
      dob_s   <= ram_dob;
    end
  end

  assign rsp_tag_a = tag_s_a;
  assign rsp_tag_b = tag_s_b;
  assign rsp_doa   = doa_s;
  assign rsp_dob   = dob_s;
`else
  assign rsp_tag_a = tag_q[PORT_A];
  assign rsp_tag_b = tag_q[PORT_B];
  assign rsp_doa   = ram_doa;
  assign rsp_dob   = ram_dob;
`endif

  logic [NREQ*WIDTH-1:0] rdata_hold;

  // Strobed slices show the RAM word now; all others replay the held value
  always_comb begin
    rsp_rdata = rdata_hold;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (rsp_tag_a.valid && (rsp_tag_a.id == ID_W'(i))) ||
                     (rsp_tag_b.valid && (rsp_tag_b.id == ID_W'(i)));
      if (rsp_tag_a.valid && (rsp_tag_a.id == ID_W'(i))) begin
        rsp_rdata[i*WIDTH +: WIDTH] = rsp_doa;
      end else if (rsp_tag_b.valid && (rsp_tag_b.id == ID_W'(i))) begin
        rsp_rdata[i*WIDTH +: WIDTH] = rsp_dob;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_hold <= '0;
    end else begin
      rdata_hold <= rsp_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_tdp_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_bram_tdp_arbiter - randomized bench with reference model  rev 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bram_tdp_arbiter;

  localparam int NREQ   = 4;
  localparam int SIZE   = 64;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = $clog2(SIZE) + 1;
`ifdef BRAM_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid, req_ready, req_we, rsp_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*WIDTH-1:0]  req_wdata, rsp_rdata;
  logic                   ram_ena, ram_enb, ram_wea, ram_web;
  logic [ADDR_W-1:0]      ram_addra, ram_addrb;
  logic [WIDTH-1:0]       ram_dia, ram_dib;
  logic [WIDTH-1:0]       ram_doa = '0, ram_dob = '0;

  always #5 clk = ~clk;

  bram_tdp_arbiter #(.NREQ(NREQ), .SIZE(SIZE), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_ena(ram_ena), .ram_enb(ram_enb), .ram_wea(ram_wea), .ram_web(ram_web),
    .ram_addra(ram_addra), .ram_addrb(ram_addrb), .ram_dia(ram_dia), .ram_dib(ram_dib),
    .ram_doa(ram_doa), .ram_dob(ram_dob)
  );

  function automatic logic [WIDTH-1:0] init_val(input int k);
    return WIDTH'(32'hA5A5_0000 + k * 32'h0001_0101);
  endfunction

  // Read-first true-dual-port RAM stand-in, preloaded on the first clock
  logic [WIDTH-1:0] mem [SIZE];
  bit               mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < SIZE; k++) mem[k] <= init_val(k);
      mem_loaded <= 1'b1;
    end else begin
      if (ram_ena) begin
        ram_doa <= mem[int'(ram_addra) % SIZE];
        if (ram_wea) mem[int'(ram_addra) % SIZE] <= ram_dia;
      end
      if (ram_enb) begin
        ram_dob <= mem[int'(ram_addrb) % SIZE];
        if (ram_web) mem[int'(ram_addrb) % SIZE] <= ram_dib;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [WIDTH-1:0]  shadow [SIZE];
  int                m_ptr;
  logic              p_valid [NREQ];
  logic              p_we    [NREQ];
  logic [ADDR_W-1:0] p_addr  [NREQ];
  logic [WIDTH-1:0]  p_wdata [NREQ];
  logic [NREQ-1:0]   pipe_v  [LAT];
  logic [WIDTH-1:0]  pipe_d  [LAT][NREQ];
  logic [WIDTH-1:0]  exp_hold [NREQ];
  int                mode;

  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      req_valid[r]                   = p_valid[r];
      req_we[r]                      = p_we[r];
      req_addr[r*ADDR_W +: ADDR_W]   = p_addr[r];
      req_wdata[r*WIDTH +: WIDTH]    = p_wdata[r];
    end
  endtask

  // New requests only for idle requesters; pending ones stay untouched
  task automatic gen();
    for (int r = 0; r < NREQ; r++) begin
      if (!p_valid[r]) begin
        p_wdata[r] = $urandom;
        case (mode)
          1: begin p_valid[r] = 1'b1; p_we[r] = 1'b0; p_addr[r] = ADDR_W'(16 + r); end
          2: begin p_valid[r] = 1'b1; p_we[r] = ($urandom_range(0, 2) == 0); p_addr[r] = ADDR_W'(3); end
          default: begin
            p_valid[r] = ($urandom_range(0, 2) != 0);
            p_we[r]    = ($urandom_range(0, 2) == 0);
            p_addr[r]  = ADDR_W'($urandom_range(0, 7));
          end
        endcase
      end
    end
  endtask

  task automatic model_grants(output logic fa, output int ia, output logic fb, output int ib);
    fa = 1'b0; fb = 1'b0; ia = 0; ib = 0;
    for (int k = 0; k < NREQ; k++) begin
      int r;
      r = (m_ptr + k) % NREQ;
      if (!p_valid[r]) continue;
      if (!fa) begin
        fa = 1'b1; ia = r;
      end else if (!fb && !((p_addr[r] == p_addr[ia]) && (p_we[r] || p_we[ia]))) begin
        fb = 1'b1; ib = r;
      end
    end
  endtask

  task automatic clear_model();
    m_ptr = 0;
    for (int s = 0; s < LAT; s++) pipe_v[s] = '0;
    for (int r = 0; r < NREQ; r++) exp_hold[r] = '0;
  endtask

  task automatic step();
    logic fa, fb;
    int ia, ib;
    logic [NREQ-1:0]  er, nv;
    logic [WIDTH-1:0] nd [NREQ];
    @(negedge clk);
    model_grants(fa, ia, fb, ib);
    er = '0;
    if (fa) er[ia] = 1'b1;
    if (fb) er[ib] = 1'b1;
    check("req_ready", req_ready, er);
    check("ram_ena",   ram_ena, fa);
    check("ram_enb",   ram_enb, fb);
    check("ram_wea",   ram_wea, fa && p_we[ia]);
    check("ram_web",   ram_web, fb && p_we[ib]);
    check("ram_addra", ram_addra, fa ? p_addr[ia] : '0);
    check("ram_addrb", ram_addrb, fb ? p_addr[ib] : '0);
    check("ram_dia",   ram_dia, fa ? p_wdata[ia] : '0);
    check("ram_dib",   ram_dib, fb ? p_wdata[ib] : '0);
    check("rsp_valid", rsp_valid, pipe_v[LAT-1]);
    for (int r = 0; r < NREQ; r++) begin
      if (pipe_v[LAT-1][r]) exp_hold[r] = pipe_d[LAT-1][r];
      check($sformatf("rsp_rdata%0d", r), rsp_rdata[r*WIDTH +: WIDTH], exp_hold[r]);
    end
    @(posedge clk);
    #1;
    nv = '0;
    for (int r = 0; r < NREQ; r++) nd[r] = '0;
    if (fa) begin nv[ia] = 1'b1; nd[ia] = shadow[int'(p_addr[ia]) % SIZE]; end
    if (fb) begin nv[ib] = 1'b1; nd[ib] = shadow[int'(p_addr[ib]) % SIZE]; end
    if (fa && p_we[ia]) shadow[int'(p_addr[ia]) % SIZE] = p_wdata[ia];
    if (fb && p_we[ib]) shadow[int'(p_addr[ib]) % SIZE] = p_wdata[ib];
    for (int s = LAT - 1; s > 0; s--) begin
      pipe_v[s] = pipe_v[s-1];
      for (int r = 0; r < NREQ; r++) pipe_d[s][r] = pipe_d[s-1][r];
    end
    pipe_v[0] = nv;
    for (int r = 0; r < NREQ; r++) pipe_d[0][r] = nd[r];
    if (fa) m_ptr = ((fb ? ib : ia) + 1) % NREQ;
    if (fa) p_valid[ia] = 1'b0;
    if (fb) p_valid[ib] = 1'b0;
    gen();
    drive();
  endtask

  initial begin
    for (int k = 0; k < SIZE; k++) shadow[k] = init_val(k);
    for (int r = 0; r < NREQ; r++) begin
      p_valid[r] = 1'b0; p_we[r] = 1'b0; p_addr[r] = '0; p_wdata[r] = '0;
    end
    clear_model();
    mode = 1;
    gen();
    drive();

    // All requesters asserting while in reset: nothing may be granted
    #12;
    check("rst_req_ready", req_ready, '0);
    check("rst_ram_ena",   ram_ena, 1'b0);
    check("rst_ram_enb",   ram_enb, 1'b0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    repeat (12)  step();
    mode = 2;
    repeat (30)  step();
    mode = 0;
    repeat (150) step();

    // Asynchronous reset with responses in flight
    mode = 1;
    gen();
    drive();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, '0);
    check("mid_rst_req_ready", req_ready, '0);
    check("mid_rst_ram_ena",   ram_ena, 1'b0);
    check("mid_rst_ram_enb",   ram_enb, 1'b0);
    check("mid_rst_rsp_rdata", rsp_rdata, '0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8)   step();
    mode = 0;
    repeat (120) step();
    mode = 2;
    repeat (20)  step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
